// File: rtl/wb_write_arbiter_pkg.sv
// wb_arb_pkg: shared types and constants for the register-file write arbiter.
//   arb_state_t  : arbiter FSM states
//   late_entry_t : one buffered late result (valid, destination, data)
//   REG_ZERO     : architectural zero register, never written
package wb_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {IDLE, QUEUED, DRAIN} arb_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } late_entry_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: bundles the MEM/WB inputs, the late-result handshake,
// the ID hazard query and the register-file write port.
//   slave  : arbiter side (consumes wb_*/late_*/id_*, drives rf_*/stall/hazard)
//   master : surrounding pipeline side
interface wb_write_arbiter_if;
  import wb_arb_pkg::*;

  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [DATA_W-1:0] wb_aluresult;
  logic [DATA_W-1:0] wb_memreaddata;
  logic [ADDR_W-1:0] wb_regdst;
  logic              late_valid;
  logic [ADDR_W-1:0] late_addr;
  logic [DATA_W-1:0] late_data;
  logic              late_ready;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              pend_hit;
  logic              stall_o;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  wb_regwrite, wb_memtoreg, wb_aluresult, wb_memreaddata, wb_regdst,
    input  late_valid, late_addr, late_data, id_rs, id_rt,
    output late_ready, pend_hit, stall_o, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb_regwrite, wb_memtoreg, wb_aluresult, wb_memreaddata, wb_regdst,
    output late_valid, late_addr, late_data, id_rs, id_rt,
    input  late_ready, pend_hit, stall_o, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_write_arbiter_late_fifo.sv
// wb_late_fifo: circular buffer of late results.
//   clk, rst_n        : clock, async active-low reset (clears all entries)
//   i_push/i_push_entry : store an entry at the tail
//   i_pop             : retire the head (clears its valid bit)
//   i_kill/i_kill_addr: invalidate every valid entry targeting i_kill_addr
//   i_cmp_rs/i_cmp_rt : per-entry address compare inputs
//   o_full/o_empty/o_count, o_head : occupancy and head entry
//   o_hit_rs/o_hit_rt : per-entry "valid and address matches" flags
module wb_late_fifo
  import wb_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  late_entry_t       i_push_entry,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [ADDR_W-1:0] i_kill_addr,
  input  logic [ADDR_W-1:0] i_cmp_rs,
  input  logic [ADDR_W-1:0] i_cmp_rt,
  output logic              o_full,
  output logic              o_empty,
  output logic [PTR_W:0]    o_count,
  output late_entry_t       o_head,
  output logic [DEPTH-1:0]  o_hit_rs,
  output logic [DEPTH-1:0]  o_hit_rt
);
  late_entry_t      r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
  logic [PTR_W-1:0] w_wr_idx, w_rd_idx;

  assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
  assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
  assign o_count  = r_wr_ptr - r_rd_ptr;
  assign o_empty  = (o_count == '0);
  assign o_full   = (o_count == (PTR_W+1)'(DEPTH));
  assign o_head   = r_mem[w_rd_idx];

  // Push slot is never occupied and the popped slot never receives a push
  // (caller guarantees no push when full, no pop when empty), so the three
  // per-slot actions below never collide on a live entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && w_wr_idx == PTR_W'(i))
          r_mem[i] <= i_push_entry;
        else if (i_pop && w_rd_idx == PTR_W'(i))
          r_mem[i].valid <= 1'b0;
        else if (i_kill && r_mem[i].valid && r_mem[i].addr == i_kill_addr)
          r_mem[i].valid <= 1'b0;
      end
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_comb begin
    o_hit_rs = '0;
    o_hit_rt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit_rs[i] = r_mem[i].valid && (r_mem[i].addr == i_cmp_rs);
      o_hit_rt[i] = r_mem[i].valid && (r_mem[i].addr == i_cmp_rt);
    end
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the MEM/WB
// stage (always preferred) and buffered late results, forcing a drain stall
// when a buffered head has waited too long, and flagging ID hazards.
//   clk, rst_n : clock, async active-low reset
//   arb        : wb_write_arbiter_if.slave (MEM/WB, late handshake, ID query,
//                register-file write port, stall request)
//
// state  | meaning
// IDLE   | buffer empty, wait counter clear
// QUEUED | late results pending, head waiting behind pipeline writes
// DRAIN  | stall asserted, pipeline write suppressed, one pop per cycle
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic               clk,
  input logic               rst_n,
  wb_write_arbiter_if.slave arb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic              w_stall, w_pipe_wr, w_accept, w_push, w_pop;
  logic              w_full, w_empty, w_next_empty;
  logic [DATA_W-1:0] w_pipe_data;
  logic [PTR_W:0]    w_count;
  late_entry_t       w_push_entry, w_head;
  logic [DEPTH-1:0]  w_hit_rs, w_hit_rt;

  assign w_stall     = (r_state == DRAIN);
  assign w_pipe_data = arb.wb_memtoreg ? arb.wb_memreaddata : arb.wb_aluresult;
  // rst_n gates the pipeline write so the port stays quiet while in reset
  // even if MEM/WB is still presenting a write.
  assign w_pipe_wr   = rst_n & arb.wb_regwrite & (arb.wb_regdst != REG_ZERO) & ~w_stall;

  // A killed head is retired even while the pipeline owns the port.
  assign w_pop    = ~w_empty & (~w_pipe_wr | ~w_head.valid);
  assign w_accept = arb.late_valid & ~w_full;

  // Writes to r0, and late results overtaken by a same-cycle pipeline write
  // to the same register, are accepted but never stored.
  assign w_push_entry.valid = (arb.late_addr != REG_ZERO) &
                              ~(w_pipe_wr & (arb.late_addr == arb.wb_regdst));
  assign w_push_entry.addr  = arb.late_addr;
  assign w_push_entry.data  = arb.late_data;
  assign w_push             = w_accept & w_push_entry.valid;

  wb_late_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill       (w_pipe_wr),
    .i_kill_addr  (arb.wb_regdst),
    .i_cmp_rs     (arb.id_rs),
    .i_cmp_rt     (arb.id_rt),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_head       (w_head),
    .o_hit_rs     (w_hit_rs),
    .o_hit_rt     (w_hit_rt)
  );

  assign arb.late_ready = ~w_full;
  assign arb.stall_o    = w_stall;
  assign arb.pend_hit   = (|w_hit_rs & (arb.id_rs != REG_ZERO)) |
                          (|w_hit_rt & (arb.id_rt != REG_ZERO));

  always_comb begin
    arb.rf_we    = 1'b0;
    arb.rf_waddr = REG_ZERO;
    arb.rf_wdata = '0;
    if (w_pipe_wr) begin
      arb.rf_we    = 1'b1;
      arb.rf_waddr = arb.wb_regdst;
      arb.rf_wdata = w_pipe_data;
    end else if (w_pop && w_head.valid) begin
      arb.rf_we    = 1'b1;
      arb.rf_waddr = w_head.addr;
      arb.rf_wdata = w_head.data;
    end
  end

  // Occupancy after this cycle's push/pop; lets the FSM leave QUEUED/DRAIN
  // in the same cycle as the last pop so stall_o drops right after it.
  assign w_next_empty = ~w_push & (w_empty | (w_pop & (w_count == (PTR_W+1)'(1))));

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_pop)
      w_wait_cnt_nxt = '0;
    else if (!w_empty && w_head.valid && r_wait_cnt != LIMIT)
      w_wait_cnt_nxt = r_wait_cnt + 1'b1;

    case (r_state)
      IDLE:    if (w_push) w_state_nxt = QUEUED;
      QUEUED:  if (w_next_empty) w_state_nxt = IDLE;
               else if (r_wait_cnt == LIMIT) w_state_nxt = DRAIN;
      DRAIN:   if (w_next_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt == IDLE) w_wait_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_wb_write_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   waited;

  wb_write_arbiter_if bus_if();

  wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] alu);
    bus_if.wb_regwrite  = we;
    bus_if.wb_regdst    = rd;
    bus_if.wb_aluresult = alu;
    bus_if.wb_memtoreg  = 1'b0;
  endtask

  task automatic late(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus_if.late_valid = v;
    bus_if.late_addr  = a;
    bus_if.late_data  = d;
  endtask

  task automatic rf_expect(input string tag, input logic we, input logic [4:0] a,
                           input logic [31:0] d);
    check({tag, "_we"}, 32'(bus_if.rf_we), 32'(we));
    check({tag, "_waddr"}, 32'(bus_if.rf_waddr), 32'(a));
    check({tag, "_wdata"}, bus_if.rf_wdata, d);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    bus_if.wb_memreaddata = 32'h0;
    late(1'b0, 5'd0, 32'h0);
    bus_if.id_rs = 5'd0;
    bus_if.id_rt = 5'd0;

    // reset state
    #12;
    check("rst_stall", 32'(bus_if.stall_o), 32'd0);
    rf_expect("rst", 1'b0, 5'd0, 32'h0);
    check("rst_pend", 32'(bus_if.pend_hit), 32'd0);
    check("rst_ready", 32'(bus_if.late_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();

    // pipeline only
    pipe(1'b1, 5'd5, 32'h0000_1111);
    bus_if.wb_memtoreg    = 1'b1;
    bus_if.wb_memreaddata = 32'hDEAD_BEEF;
    #1 rf_expect("pipe_mem", 1'b1, 5'd5, 32'hDEAD_BEEF);
    bus_if.wb_memtoreg = 1'b0;
    #1 rf_expect("pipe_alu", 1'b1, 5'd5, 32'h0000_1111);
    bus_if.wb_regdst = 5'd0;
    #1 rf_expect("pipe_r0", 1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    tick();

    // idle port: accept at N, write at N+1
    late(1'b1, 5'd7, 32'h1234);
    bus_if.id_rs = 5'd7;
    #1;
    check("idle_ready", 32'(bus_if.late_ready), 32'd1);
    check("idle_n_we", 32'(bus_if.rf_we), 32'd0);
    check("idle_n_pend", 32'(bus_if.pend_hit), 32'd0);
    tick();
    late(1'b0, 5'd0, 32'h0);
    #1;
    rf_expect("idle_n1", 1'b1, 5'd7, 32'h1234);
    check("idle_n1_pend", 32'(bus_if.pend_hit), 32'd1);
    tick();
    #1;
    check("idle_n2_we", 32'(bus_if.rf_we), 32'd0);
    check("idle_n2_pend", 32'(bus_if.pend_hit), 32'd0);
    bus_if.id_rs = 5'd0;
    tick();

    // starvation: two entries behind a busy pipeline
    pipe(1'b1, 5'd3, 32'h0000_00A0);
    late(1'b1, 5'd10, 32'h100);
    #1 rf_expect("stv_s0", 1'b1, 5'd3, 32'hA0);
    tick();
    late(1'b1, 5'd11, 32'h111);
    #1 check("stv_s1_ready", 32'(bus_if.late_ready), 32'd1);
    tick();
    late(1'b0, 5'd0, 32'h0);
    bus_if.id_rt = 5'd11;
    #1 check("stv_pend_rt", 32'(bus_if.pend_hit), 32'd1);
    tick();
    bus_if.id_rt = 5'd0;
    #1 check("stv_s3_stall", 32'(bus_if.stall_o), 32'd0);
    tick();
    #1 check("stv_s4_stall", 32'(bus_if.stall_o), 32'd0);
    tick();
    #1;
    check("stv_s5_stall", 32'(bus_if.stall_o), 32'd0);
    rf_expect("stv_s5", 1'b1, 5'd3, 32'hA0);
    tick();
    #1;
    check("stv_s6_stall", 32'(bus_if.stall_o), 32'd1);
    rf_expect("stv_s6", 1'b1, 5'd10, 32'h100);
    tick();
    #1;
    check("stv_s7_stall", 32'(bus_if.stall_o), 32'd1);
    rf_expect("stv_s7", 1'b1, 5'd11, 32'h111);
    tick();
    #1;
    check("stv_s8_stall", 32'(bus_if.stall_o), 32'd0);
    rf_expect("stv_s8", 1'b1, 5'd3, 32'hA0);
    tick();

    // WAW kill
    pipe(1'b1, 5'd3, 32'h3333);
    late(1'b1, 5'd9, 32'hAAAA);
    #1 rf_expect("waw_k0", 1'b1, 5'd3, 32'h3333);
    tick();
    pipe(1'b1, 5'd9, 32'hBBBB);
    late(1'b1, 5'd9, 32'hCCCC);
    bus_if.id_rs = 5'd9;
    #1;
    rf_expect("waw_k1", 1'b1, 5'd9, 32'hBBBB);
    check("waw_k1_pend", 32'(bus_if.pend_hit), 32'd1);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    late(1'b0, 5'd0, 32'h0);
    #1;
    check("waw_k2_we", 32'(bus_if.rf_we), 32'd0);
    check("waw_k2_pend", 32'(bus_if.pend_hit), 32'd0);
    tick();
    #1 check("waw_k3_we", 32'(bus_if.rf_we), 32'd0);
    bus_if.id_rs = 5'd0;
    tick();

    // full / back-pressure
    pipe(1'b1, 5'd3, 32'h5555);
    late(1'b1, 5'd12, 32'h12);
    tick();
    late(1'b1, 5'd13, 32'h13);
    tick();
    late(1'b1, 5'd14, 32'h14);
    #1 check("full_f2_ready", 32'(bus_if.late_ready), 32'd0);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    #1;
    check("full_f3_ready", 32'(bus_if.late_ready), 32'd0);
    rf_expect("full_f3", 1'b1, 5'd12, 32'h12);
    tick();
    #1;
    check("full_f4_ready", 32'(bus_if.late_ready), 32'd1);
    rf_expect("full_f4", 1'b1, 5'd13, 32'h13);
    tick();
    late(1'b0, 5'd0, 32'h0);
    #1 rf_expect("full_f5", 1'b1, 5'd14, 32'h14);
    tick();
    #1 check("full_f6_we", 32'(bus_if.rf_we), 32'd0);
    tick();

    // async reset during DRAIN
    pipe(1'b1, 5'd3, 32'h6666);
    late(1'b1, 5'd20, 32'h20);
    tick();
    late(1'b1, 5'd21, 32'h21);
    tick();
    late(1'b0, 5'd0, 32'h0);
    bus_if.id_rs = 5'd21;
    waited = 0;
    #1;
    while (!bus_if.stall_o && waited < 20) begin
      tick();
      #1;
      waited++;
    end
    check("rd_drain_wait", 32'(waited), 32'd4);
    check("rd_stall", 32'(bus_if.stall_o), 32'd1);
    check("rd_pend", 32'(bus_if.pend_hit), 32'd1);
    rf_expect("rd_pop", 1'b1, 5'd20, 32'h20);
    #1 rst_n = 1'b0;
    #1;
    check("rd_rst_stall", 32'(bus_if.stall_o), 32'd0);
    rf_expect("rd_rst", 1'b0, 5'd0, 32'h0);
    check("rd_rst_pend", 32'(bus_if.pend_hit), 32'd0);
    check("rd_rst_ready", 32'(bus_if.late_ready), 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    #1;
    check("rd_post_we", 32'(bus_if.rf_we), 32'd0);
    check("rd_post_pend", 32'(bus_if.pend_hit), 32'd0);
    check("rd_post_stall", 32'(bus_if.stall_o), 32'd0);
    tick();
    #1 check("rd_post2_we", 32'(bus_if.rf_we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
